cfg_xfer_arbiter: RTL and testbench

Source-domain scheduler that shares one slow multi-bit cross-clock configuration word between NUM_REQ requesters. It grants requesters round-robin and latches the winner's tagged word onto a shared bus. It holds that word unchanged for HOLD_CYCLES so the destination-side stability synchronizer (three equal samples) can capture it. It then acknowledges the requester and enforces a one-cycle gap before the next grant.

---
 rtl/cfg_xfer_arbiter_pkg.sv | 29 ++
 rtl/cfg_xfer_arbiter_if.sv | 27 ++
 rtl/cfg_xfer_arbiter_rr_pick.sv | 30 +++
 rtl/cfg_xfer_arbiter.sv | 129 ++++++++++++
 tb/tb_cfg_xfer_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_xfer_arbiter_pkg.sv
// Shared types and bus_word layout helpers for the configuration-word transfer arbiter.
package cfg_xfer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } xfer_state_e;

  localparam int unsigned MIN_HOLD_CYCLES = 4;

  // bus_word = {seq, addr, data}, data in the low bits
  function automatic int unsigned data_lsb();
    return 0;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned seq_pos(input int unsigned addr_width, input int unsigned data_width);
    return addr_width + data_width;
  endfunction

  function automatic int unsigned bus_word_width(input int unsigned addr_width, input int unsigned data_width);
    return 1 + addr_width + data_width;
  endfunction

endpackage

// File: rtl/cfg_xfer_arbiter_if.sv
// Requester-side bundle: level requests, packed payloads, completion pulses and the shared bus word.
interface cfg_xfer_arbiter_if
  import cfg_xfer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned BW = bus_word_width(ADDR_WIDTH, DATA_WIDTH);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          busy;
  logic [BW-1:0]                 bus_word;
  logic [ADDR_WIDTH-1:0]         grant_idx;

  modport master (
    output req, req_data,
    input  ack, busy, bus_word, grant_idx
  );

  modport slave (
    input  req, req_data,
    output ack, busy, bus_word, grant_idx
  );
endinterface

// File: rtl/cfg_xfer_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward from ptr+1, wrapping.
module cfg_xfer_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [ADDR_WIDTH-1:0] ptr_i,
  output logic [ADDR_WIDTH-1:0] idx_o,
  output logic                  valid_o
);
  // Padding to the full index range keeps every candidate index in bounds.
  logic [2**ADDR_WIDTH-1:0] req_ext;
  logic [ADDR_WIDTH:0]      cand;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req_i;
    idx_o                = '0;
    valid_o              = 1'b0;
    cand                 = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_i} + (ADDR_WIDTH+1)'(i);
      if (cand >= (ADDR_WIDTH+1)'(NUM_REQ)) cand = cand - (ADDR_WIDTH+1)'(NUM_REQ);
      if (!valid_o && req_ext[cand[ADDR_WIDTH-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[ADDR_WIDTH-1:0];
      end
    end
  end
endmodule

// File: rtl/cfg_xfer_arbiter.sv
// Round-robin scheduler that holds one tagged configuration word stable long enough for a
// destination-side three-sample synchronizer, then acks the requester and idles one gap cycle.
module cfg_xfer_arbiter
  import cfg_xfer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  cfg_xfer_arbiter_if.slave xfer
);
  localparam int unsigned BW       = bus_word_width(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned SEQ_POS  = seq_pos(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int unsigned DATA_LSB = data_lsb();
  localparam int unsigned CNT_W    = $clog2(HOLD_CYCLES);

  if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_hold
    $error("HOLD_CYCLES (%0d) must be at least %0d", HOLD_CYCLES, MIN_HOLD_CYCLES);
  end
  if ((2 ** ADDR_WIDTH) < NUM_REQ) begin : g_bad_addr
    $error("ADDR_WIDTH (%0d) too narrow for NUM_REQ (%0d)", ADDR_WIDTH, NUM_REQ);
  end

  xfer_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  seq_q, seq_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [BW-1:0]         bus_word_q, bus_word_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] pick_idx;
  logic                  pick_valid;
  logic [DATA_WIDTH-1:0] pick_data;

  cfg_xfer_arbiter_rr_pick #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rr_pick (
    .req_i   (xfer.req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ADDR_WIDTH'(i)) pick_data = xfer.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      seq_q       <= 1'b0;
      ptr_q       <= ADDR_WIDTH'(NUM_REQ - 1);
      grant_idx_q <= '0;
      bus_word_q  <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      bus_word_q  <= bus_word_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    bus_word_d  = bus_word_q;
    ack_d       = '0;
    busy_d      = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          bus_word_d[SEQ_POS]                   = ~seq_q;
          bus_word_d[ADDR_LSB +: ADDR_WIDTH]    = pick_idx;
          bus_word_d[DATA_LSB +: DATA_WIDTH]    = pick_data;
          seq_d       = ~seq_q;
          grant_idx_d = pick_idx;
          ptr_d       = pick_idx;
          cnt_d       = CNT_W'(HOLD_CYCLES - 1);
          busy_d      = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (grant_idx_q == ADDR_WIDTH'(i));
          end
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        // No arbitration here: a registered requester's req is still high this cycle.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign xfer.ack       = ack_q;
  assign xfer.busy      = busy_q;
  assign xfer.bus_word  = bus_word_q;
  assign xfer.grant_idx = grant_idx_q;
endmodule

// File: tb/tb_cfg_xfer_arbiter.sv
// Directed bench for cfg_xfer_arbiter (4 requesters, 16-bit data, hold 16) with a slow-clock
// three-sample synchronizer model on bus_word.
module tb_cfg_xfer_arbiter;
  logic clk;
  logic rst;
  logic dclk;

  int unsigned n_cmp;
  int unsigned n_mis;

  cfg_xfer_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16), .ADDR_WIDTH(4)) xif ();

  cfg_xfer_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (4),
    .HOLD_CYCLES (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .xfer (xif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Destination clock 3.7x slower, offset so its edges never coincide with clk edges.
  initial begin
    dclk = 1'b0;
    #6;
    forever #37 dclk = ~dclk;
  end

  logic [20:0] s0, s1, s2, dout;
  bit          sync_en;
  logic [20:0] got_q[$];

  always @(posedge dclk) begin
    s0 <= xif.bus_word;
    s1 <= s0;
    s2 <= s1;
    if (!sync_en) dout <= '0;
    else if (s0 == s1 && s1 == s2 && s2 != dout) begin
      dout <= s2;
      got_q.push_back(s2);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] mk(input bit s, input int unsigned idx, input logic [15:0] d);
    logic [3:0] a;
    a = 4'(idx);
    return {s, a, d};
  endfunction

  task automatic set_data(input int unsigned i, input logic [15:0] v);
    xif.req_data[i*16 +: 16] = v;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    xif.req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits for a non-zero ack, noting whether bus_word moved meanwhile.
  task automatic wait_ack(output int unsigned cyc, output logic [3:0] a, output bit stable);
    logic [20:0] w0;
    w0     = xif.bus_word;
    cyc    = 0;
    a      = '0;
    stable = 1'b1;
    while (a == '0 && cyc < 40) begin
      tick();
      cyc++;
      if (xif.bus_word != w0) stable = 1'b0;
      a = xif.ack;
    end
    if (a == '0) check("ack_timeout", 64'(cyc), 64'd16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    logic [3:0]  a;
    bit          stable;
    int unsigned acks;

    n_cmp    = 0;
    n_mis    = 0;
    sync_en  = 1'b0;
    rst      = 1'b1;
    xif.req  = '0;
    xif.req_data = '0;

    // Reset state
    do_reset();
    check("rst_bus_word", 64'(xif.bus_word), 64'h0);
    check("rst_ack", 64'(xif.ack), 64'h0);
    check("rst_busy", 64'(xif.busy), 64'h0);
    check("rst_grant_idx", 64'(xif.grant_idx), 64'h0);

    // Single request on index 2
    set_data(2, 16'hBEEF);
    xif.req = 4'b0100;
    tick();
    check("single_word", 64'(xif.bus_word), 64'h12BEEF);
    check("single_busy", 64'(xif.busy), 64'h1);
    check("single_gidx", 64'(xif.grant_idx), 64'h2);
    wait_ack(cyc, a, stable);
    check("single_latency", 64'(cyc), 64'd16);
    check("single_ack", 64'(a), 64'h4);
    check("single_stable", 64'(stable), 64'h1);
    check("single_busy_at_ack", 64'(xif.busy), 64'h1);
    tick();
    xif.req = '0;
    check("single_ack_clr", 64'(xif.ack), 64'h0);
    check("single_busy_clr", 64'(xif.busy), 64'h0);
    tick();
    check("single_idle_hold", 64'(xif.bus_word), 64'h12BEEF);

    // All four requesting continuously
    do_reset();
    for (int unsigned i = 0; i < 4; i++) set_data(i, 16'hA000 + 16'(i));
    xif.req = 4'hF;
    tick();
    for (int unsigned k = 0; k < 5; k++) begin
      check("rr_gidx", 64'(xif.grant_idx), 64'(k % 4));
      check("rr_word", 64'(xif.bus_word), 64'(mk(k % 2 == 0, k % 4, 16'hA000 + 16'(k % 4))));
      wait_ack(cyc, a, stable);
      check("rr_latency", 64'(cyc), 64'd16);
      check("rr_ack", 64'(a), 64'(4'b0001 << (k % 4)));
      if (k == 4) xif.req = '0;
      tick();
      check("rr_gap_busy", 64'(xif.busy), 64'h0);
      tick();
    end
    check("rr_end_idle", 64'(xif.busy), 64'h0);

    // Payload change during hold is ignored until the next grant
    do_reset();
    set_data(1, 16'h1234);
    xif.req = 4'b0010;
    tick();
    check("hold_word0", 64'(xif.bus_word), 64'h111234);
    repeat (5) tick();
    set_data(1, 16'h5678);
    wait_ack(cyc, a, stable);
    check("hold_latency", 64'(cyc), 64'd11);
    check("hold_stable", 64'(stable), 64'h1);
    check("hold_word_end", 64'(xif.bus_word), 64'h111234);
    tick();
    tick();
    check("hold_regrant_word", 64'(xif.bus_word), 64'h015678);
    xif.req = '0;
    wait_ack(cyc, a, stable);
    tick();
    tick();

    // Stale req held one cycle after ack, requester 3 pending
    do_reset();
    set_data(0, 16'h0A0A);
    set_data(3, 16'h3C3C);
    xif.req = 4'b1001;
    tick();
    check("stale_first", 64'(xif.bus_word), 64'(mk(1'b1, 0, 16'h0A0A)));
    wait_ack(cyc, a, stable);
    check("stale_ack", 64'(a), 64'h1);
    tick();
    check("stale_gap_busy", 64'(xif.busy), 64'h0);
    check("stale_gap_word", 64'(xif.bus_word), 64'(mk(1'b1, 0, 16'h0A0A)));
    xif.req = 4'b1000;
    tick();
    check("stale_next_word", 64'(xif.bus_word), 64'(mk(1'b0, 3, 16'h3C3C)));
    check("stale_next_gidx", 64'(xif.grant_idx), 64'h3);
    xif.req = '0;
    wait_ack(cyc, a, stable);
    check("stale_next_ack", 64'(a), 64'h8);

    // Reset while the hold counter is 7
    do_reset();
    set_data(0, 16'h7777);
    xif.req = 4'b0001;
    tick();
    repeat (8) tick();
    rst     = 1'b1;
    xif.req = '0;
    tick();
    rst = 1'b0;
    check("abort_word", 64'(xif.bus_word), 64'h0);
    check("abort_busy", 64'(xif.busy), 64'h0);
    check("abort_ack", 64'(xif.ack), 64'h0);
    acks = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      if (xif.ack != '0) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'h0);
    set_data(0, 16'h00C3);
    xif.req = 4'b0001;
    tick();
    check("abort_regrant", 64'(xif.bus_word), 64'h1000C3);
    xif.req = '0;
    wait_ack(cyc, a, stable);
    tick();
    tick();

    // Synchronizer at 1:3.7 sees every word exactly once
    do_reset();
    repeat (12) tick();
    got_q.delete();
    sync_en = 1'b1;
    for (int unsigned i = 0; i < 4; i++) set_data(i, 16'hC0D0 + 16'(i));
    xif.req = 4'hF;
    for (int unsigned k = 0; k < 6; k++) begin
      wait_ack(cyc, a, stable);
      check("sync_ack", 64'(a), 64'(4'b0001 << (k % 4)));
    end
    xif.req = '0;
    repeat (30) tick();
    sync_en = 1'b0;
    check("sync_count", 64'(got_q.size()), 64'd6);
    for (int unsigned k = 0; k < 6; k++) begin
      if (k < got_q.size())
        check("sync_word", 64'(got_q[k]), 64'(mk(k % 2 == 0, k % 4, 16'hC0D0 + 16'(k % 4))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
